ecc_secded_pipe: RTL and testbench
==================================

// Module: ecc_secded_pipe
// PURPOSE
// - Parametrised, pipelined SECDED (extended Hamming) decoder/corrector for FIFO and RAM read paths.
// - Replaces fixed-width combinational ECC blocks; adds valid/ready flow control and error counters.
// - Adds first-error capture registers, readable by the CSR layer.
// - Sits between the storage array read port and the consumer.
// PARAMETERS
// - DATA_WIDTH    60  data bits per word
// - PARITY_WIDTH  8   check bits; requirement 2**(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH (elaboration $error otherwise)
// - TAG_WIDTH     8   sideband tag (e.g. read address) carried alongside each word
// - CNT_WIDTH     16  width of the saturating error counters
// PORTS
// - clk               in   1    clock
// - rst_n             in   1    synchronous active-low reset
// - in_valid          in   1    input word valid
// - in_ready          out  1    block can accept the input word
// - in_data           in   DW   data read from storage
// - in_parity         in   PW   check bits read from storage
// - in_tag            in   TW   sideband tag
// - cfg_bypass        in   1    1: no correction and no error flags; sampled with each accepted word
// - out_valid         out  1    output word valid
// - out_ready         in   1    consumer accepts the output word
// - out_data          out  DW   corrected data
// - out_tag           out  TW   tag, delayed to match out_data
// - out_sbit_err      out  1    single-bit error detected and corrected
// - out_dbit_err      out  1    uncorrectable error
// - out_syndrome      out  PW   syndrome of the output word
// - sbit_cnt/dbit_cnt out  CW   saturating error counts
// - cnt_clr           in   1    synchronous clear of both counters
// - log_valid         out  1    error log holds an entry
// - log_dbit          out  1    logged entry is uncorrectable
// - log_tag           out  TW   tag of the logged word
// - log_syndrome      out  PW   syndrome of the logged word
// - log_clr           in   1    clears log_valid
// BEHAVIOUR
// - Code, with P = PW-1:
//   - Data bits occupy the non-power-of-2 codeword positions 1..DW+P, in ascending order.
//   - p[i] (i<P) = XOR of the data bits whose position has bit i set.
//   - p[P] makes the whole codeword {data,p} even parity.
// - Syndrome:
//   - s[P-1:0] = in_parity[P-1:0] ^ recomputed p[P-1:0].
//   - s[P] = ^{in_data,in_parity}.
// - Decode:
//   - s==0: no error.
//   - s[P]=1, s[P-1:0]==0 or a power of 2: check-bit error; sbit=1, data unchanged.
//   - s[P]=1, s[P-1:0] = position of a data bit: flip that bit; sbit=1.
//   - s[P]=1, s[P-1:0] > DW+P: dbit=1, data unchanged.
//   - s[P]=0, s[P-1:0]!=0: dbit=1, data unchanged.
//   - sbit and dbit are never both 1.
// - Pipeline:
//   - S1 registers data, tag, bypass and syndrome. S2 registers the corrected data and the flags.
//   - Latency: 2 cycles from the in_valid&in_ready edge to out_valid, when there is no backpressure.
//   - Full throughput: 1 word/cycle.
//   - in_ready = !s1_vld | s1_adv, where s1_adv = !s2_vld | out_ready. in_ready is combinational on out_ready.
//   - out_* are held stable while out_valid & !out_ready. No word is dropped or duplicated.
// - Bypass: out_data = in_data, sbit = dbit = 0, and counters and log are untouched. out_syndrome still reports the syndrome.
// - Counters:
//   - A counter increments when a word with the matching flag loads into S2.
//   - Counters saturate at all-ones.
//   - cnt_clr has priority over a same-cycle increment: the result is 0 and that event is not counted.
// - Log:
//   - Captured on S2 load of an errored word when log_valid=0.
//   - A dbit word also overwrites a logged sbit entry.
//   - Otherwise the log is frozen.
//   - log_clr together with a new error in the same cycle: the new error is captured (log_valid stays 1).
// - Reset: all valids, flags, counters, log fields and out_data/out_tag/out_syndrome are 0; in_ready=1 the cycle after reset.
// - Reset mid-operation discards in-flight words with no output.
// CONFIGURATION
// - ECC_ERR_INJ_EN defined:
//   - Adds ports inj_data_mask (in, DW) and inj_parity_mask (in, PW).
//   - The masks are XORed onto in_data/in_parity before the syndrome and apply on accepted words only.
// - ECC_ERR_INJ_EN undefined: the ports and XOR logic are absent.
// TESTING
// - DW=60, PW=8: 1000 random clean codewords, out_ready=1 -> out_data==in_data, no flags, 2-cycle latency, 1 word/cycle.
// - Flip data bit 0, then bit 59, then parity bit 7 -> each word sbit=1 and data corrected; sbit_cnt=3, log holds the first tag with its syndrome.
// - Flip data bits 3 and 17 -> dbit=1, data unchanged; the dbit entry overwrites the sbit log; dbit_cnt=1.
// - Toggle out_ready randomly at 50%, 500 words -> in-order, lossless, outputs stable while stalled.
// - CNT_WIDTH=4, 20 sbit words -> sbit_cnt saturates at 15; cnt_clr on an error cycle -> 0.
// - cfg_bypass=1 with an injected double error -> raw data out, flags 0, counters unchanged; rst_n low mid-stream -> all outputs 0.

Source files
------------

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: two-stage pipelined SECDED (extended Hamming) decoder and
// corrector for storage read paths, with valid/ready flow control, saturating
// error counters and a first-error log.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake
//   in_data/in_parity/in_tag   stored word, its check bits and a sideband tag
//   cfg_bypass                 per-word: pass raw data, suppress flags
//   out_valid/out_ready        output handshake
//   out_data/out_tag           corrected data and its tag
//   out_sbit_err/out_dbit_err  corrected / uncorrectable flags
//   out_syndrome               syndrome of the output word
//   sbit_cnt/dbit_cnt/cnt_clr  saturating error counters and their clear
//   log_*/log_clr              first-error capture registers and their clear
//
// Optional feature (macro ECC_ERR_INJ_EN): adds inj_data_mask/inj_parity_mask,
// XORed onto every accepted word ahead of the syndrome logic.
module ecc_secded_pipe #(
  parameter int unsigned DATA_WIDTH   = 60,
  parameter int unsigned PARITY_WIDTH = 8,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [PARITY_WIDTH-1:0] in_parity,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  input  logic                    cfg_bypass,
`ifdef ECC_ERR_INJ_EN
  input  logic [DATA_WIDTH-1:0]   inj_data_mask,
  input  logic [PARITY_WIDTH-1:0] inj_parity_mask,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_sbit_err,
  output logic                    out_dbit_err,
  output logic [PARITY_WIDTH-1:0] out_syndrome,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  input  logic                    cnt_clr,
  output logic                    log_valid,
  output logic                    log_dbit,
  output logic [TAG_WIDTH-1:0]    log_tag,
  output logic [PARITY_WIDTH-1:0] log_syndrome,
  input  logic                    log_clr
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = PARITY_WIDTH;
  localparam int unsigned TW = TAG_WIDTH;
  localparam int unsigned CW = CNT_WIDTH;
  localparam int unsigned P  = PW - 1;

  if ((2 ** (PARITY_WIDTH - 1)) < (DATA_WIDTH + PARITY_WIDTH)) begin : g_bad_params
    $error("ecc_secded_pipe: PARITY_WIDTH too small for DATA_WIDTH");
  end

  // Codeword position of data bit idx: the idx-th non-power-of-2 position.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned k = 1; k < (2 ** P); k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == idx) pos = k;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic [P-1:0][DW-1:0] pmask;   // pmask[i][j]: data bit j contributes to p[i]
  logic [DW-1:0]        hit;     // syndrome points at data bit j

  logic [DW-1:0] dat_x;
  logic [PW-1:0] par_x;
  logic [PW-1:0] syn_d;

  logic          s1_vld_q, s1_byp_q;
  logic [DW-1:0] s1_data_q;
  logic [TW-1:0] s1_tag_q;
  logic [PW-1:0] s1_syn_q;

  logic          s2_vld_q, s2_sbit_q, s2_dbit_q;
  logic [DW-1:0] s2_data_q;
  logic [TW-1:0] s2_tag_q;
  logic [PW-1:0] s2_syn_q;

  logic [CW-1:0] sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic          log_valid_q, log_valid_d, log_dbit_q, log_dbit_d;
  logic [TW-1:0] log_tag_q, log_tag_d;
  logic [PW-1:0] log_syn_q, log_syn_d;

  logic          s1_adv, ld1, ld2, cap;
  logic          sbit_c, dbit_c;
  logic [DW-1:0] cdata;
  logic [P-1:0]  syn_lo;

  for (genvar j = 0; j < DW; j++) begin : g_pos
    localparam int unsigned POS = data_pos(j);
    for (genvar i = 0; i < P; i++) begin : g_bit
      assign pmask[i][j] = 1'((POS >> i) & 1);
    end
    assign hit[j] = (s1_syn_q[P-1:0] == P'(POS));
  end

`ifdef ECC_ERR_INJ_EN
  assign dat_x = in_data ^ inj_data_mask;
  assign par_x = in_parity ^ inj_parity_mask;
`else
  assign dat_x = in_data;
  assign par_x = in_parity;
`endif

  assign s1_adv   = !s2_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s1_adv;
  assign ld1      = in_valid && in_ready;
  assign ld2      = s1_vld_q && s1_adv;

  always_comb begin
    syn_d = '0;
    for (int unsigned i = 0; i < P; i++) begin
      syn_d[i] = par_x[i] ^ (^(dat_x & pmask[i]));
    end
    syn_d[P] = ^{dat_x, par_x};
  end

  always_comb begin
    syn_lo = s1_syn_q[P-1:0];
    sbit_c = 1'b0;
    dbit_c = 1'b0;
    cdata  = s1_data_q;
    if (!s1_byp_q && (s1_syn_q != '0)) begin
      if (s1_syn_q[P]) begin
        // zero or power of two: the flipped bit is a check bit
        if ((syn_lo & (syn_lo - P'(1))) == '0) begin
          sbit_c = 1'b1;
        end else if (|hit) begin
          sbit_c = 1'b1;
          cdata  = s1_data_q ^ hit;
        end else begin
          dbit_c = 1'b1;
        end
      end else begin
        dbit_c = 1'b1;
      end
    end
  end

  always_comb begin
    sbit_cnt_d = sbit_cnt_q;
    dbit_cnt_d = dbit_cnt_q;
    if (cnt_clr) begin
      sbit_cnt_d = '0;
      dbit_cnt_d = '0;
    end else if (ld2) begin
      if (sbit_c && (sbit_cnt_q != '1)) sbit_cnt_d = sbit_cnt_q + CW'(1);
      if (dbit_c && (dbit_cnt_q != '1)) dbit_cnt_d = dbit_cnt_q + CW'(1);
    end
  end

  // log_clr frees the log in the same cycle, so a coinciding error is captured
  assign cap = ld2 && (sbit_c || dbit_c) &&
               (!log_valid_q || log_clr || (dbit_c && !log_dbit_q));

  always_comb begin
    log_valid_d = log_valid_q;
    log_dbit_d  = log_dbit_q;
    log_tag_d   = log_tag_q;
    log_syn_d   = log_syn_q;
    if (cap) begin
      log_valid_d = 1'b1;
      log_dbit_d  = dbit_c;
      log_tag_d   = s1_tag_q;
      log_syn_d   = s1_syn_q;
    end else if (log_clr) begin
      log_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      s1_syn_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_sbit_q   <= 1'b0;
      s2_dbit_q   <= 1'b0;
      s2_data_q   <= '0;
      s2_tag_q    <= '0;
      s2_syn_q    <= '0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      log_valid_q <= 1'b0;
      log_dbit_q  <= 1'b0;
      log_tag_q   <= '0;
      log_syn_q   <= '0;
    end else begin
      if (in_ready) s1_vld_q <= in_valid;
      if (ld1) begin
        s1_data_q <= dat_x;
        s1_tag_q  <= in_tag;
        s1_byp_q  <= cfg_bypass;
        s1_syn_q  <= syn_d;
      end
      if (s1_adv) s2_vld_q <= s1_vld_q;
      if (ld2) begin
        s2_data_q <= cdata;
        s2_tag_q  <= s1_tag_q;
        s2_syn_q  <= s1_syn_q;
        s2_sbit_q <= sbit_c;
        s2_dbit_q <= dbit_c;
      end
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      log_valid_q <= log_valid_d;
      log_dbit_q  <= log_dbit_d;
      log_tag_q   <= log_tag_d;
      log_syn_q   <= log_syn_d;
    end
  end

  assign out_valid    = s2_vld_q;
  assign out_data     = s2_data_q;
  assign out_tag      = s2_tag_q;
  assign out_sbit_err = s2_sbit_q;
  assign out_dbit_err = s2_dbit_q;
  assign out_syndrome = s2_syn_q;
  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign log_valid    = log_valid_q;
  assign log_dbit     = log_dbit_q;
  assign log_tag      = log_tag_q;
  assign log_syndrome = log_syn_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
module tb_ecc_secded_pipe;

  localparam int DW = 60;
  localparam int PW = 8;
  localparam int TW = 8;
  localparam int P  = PW - 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          sbit;
    logic          dbit;
    logic [PW-1:0] syn;
    logic          lat;
    int            acc;
  } exp_t;

  logic clk, rst_n, in_valid, cfg_bypass, out_ready, cnt_clr, log_clr;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_parity;
  logic [TW-1:0] in_tag;

  logic          in_ready, out_valid, out_sbit_err, out_dbit_err, log_valid, log_dbit;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag, log_tag;
  logic [PW-1:0] out_syndrome, log_syndrome;
  logic [15:0]   sbit_cnt, dbit_cnt;

  logic          u4_in_ready, u4_out_valid, u4_sbit, u4_dbit, u4_log_valid, u4_log_dbit;
  logic [DW-1:0] u4_out_data;
  logic [TW-1:0] u4_out_tag, u4_log_tag;
  logic [PW-1:0] u4_out_syn, u4_log_syn;
  logic [3:0]    sbit_cnt4, dbit_cnt4;

  int   n_cmp, n_bad, cyc, rdy_mode;
  logic lat_mode;
  exp_t cur_exp;
  exp_t sb[$];
  int   exp_s, exp_d;
  logic exp_lv, exp_ld;
  logic [TW-1:0] exp_ltag;
  logic [PW-1:0] exp_lsyn;

  ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_WIDTH(TW), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_parity(in_parity), .in_tag(in_tag), .cfg_bypass(cfg_bypass),
`ifdef ECC_ERR_INJ_EN
    .inj_data_mask('0), .inj_parity_mask('0),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err), .out_syndrome(out_syndrome),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .cnt_clr(cnt_clr),
    .log_valid(log_valid), .log_dbit(log_dbit), .log_tag(log_tag),
    .log_syndrome(log_syndrome), .log_clr(log_clr)
  );

  ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_WIDTH(TW), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u4_in_ready),
    .in_data(in_data), .in_parity(in_parity), .in_tag(in_tag), .cfg_bypass(cfg_bypass),
`ifdef ECC_ERR_INJ_EN
    .inj_data_mask('0), .inj_parity_mask('0),
`endif
    .out_valid(u4_out_valid), .out_ready(out_ready), .out_data(u4_out_data), .out_tag(u4_out_tag),
    .out_sbit_err(u4_sbit), .out_dbit_err(u4_dbit), .out_syndrome(u4_out_syn),
    .sbit_cnt(sbit_cnt4), .dbit_cnt(dbit_cnt4), .cnt_clr(cnt_clr),
    .log_valid(u4_log_valid), .log_dbit(u4_log_dbit), .log_tag(u4_log_tag),
    .log_syndrome(u4_log_syn), .log_clr(log_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference encoder: build the codeword by position, then fold positions.
  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [127:0]  cw;
    logic [PW-1:0] p;
    int            j;
    cw = '0;
    p  = '0;
    j  = 0;
    for (int k = 1; k < 128; k++) begin
      if (((k & (k - 1)) != 0) && (j < DW)) begin
        cw[k] = d[j];
        j++;
      end
    end
    for (int i = 0; i < P; i++) begin
      for (int k = 1; k < 128; k++) begin
        if (((k >> i) & 1) == 1) p[i] = p[i] ^ cw[k];
      end
    end
    p[P] = ^{d, p[P-1:0]};
    return p;
  endfunction

  function automatic logic [PW-1:0] synd(input logic [DW-1:0] rd, input logic [PW-1:0] rp);
    logic [PW-1:0] q, s;
    q = enc(rd);
    s[P-1:0] = rp[P-1:0] ^ q[P-1:0];
    s[P]     = ^{rd, rp};
    return s;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: push on accept, compare front while out_valid, pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        e     = cur_exp;
        e.acc = cyc;
        sb.push_back(e);
        if (e.sbit) exp_s++;
        if (e.dbit) exp_d++;
        if ((e.sbit || e.dbit) && (!exp_lv || (e.dbit && !exp_ld))) begin
          exp_lv   = 1'b1;
          exp_ld   = e.dbit;
          exp_ltag = e.tag;
          exp_lsyn = e.syn;
        end
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_val("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          e = sb[0];
          check_val("out_data", 64'(out_data), 64'(e.data));
          check_val("out_tag", 64'(out_tag), 64'(e.tag));
          check_val("out_sbit", 64'(out_sbit_err), 64'(e.sbit));
          check_val("out_dbit", 64'(out_dbit_err), 64'(e.dbit));
          check_val("out_syndrome", 64'(out_syndrome), 64'(e.syn));
          if (e.lat) check_val("latency", 64'(cyc - e.acc), 64'(2));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic [TW-1:0] tag,
                           input logic [DW-1:0] df, input logic [PW-1:0] pf, input logic byp);
    logic [PW-1:0] par;
    int            nerr, n;
    logic          acc;
    par        = enc(d);
    in_data    = d ^ df;
    in_parity  = par ^ pf;
    in_tag     = tag;
    cfg_bypass = byp;
    in_valid   = 1'b1;
    nerr       = $countones({df, pf});
    cur_exp.tag  = tag;
    cur_exp.syn  = synd(d ^ df, par ^ pf);
    cur_exp.lat  = lat_mode;
    cur_exp.sbit = !byp && (nerr == 1);
    cur_exp.dbit = !byp && (nerr == 2);
    cur_exp.data = (byp || nerr == 2) ? (d ^ df) : d;
    cur_exp.acc  = 0;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    check_val("accept", 64'(acc), 64'(1));
  endtask

  task automatic rand_flip(input int nbits, output logic [DW-1:0] df, output logic [PW-1:0] pf);
    logic [DW+PW-1:0] m;
    int a, b;
    m = '0;
    a = $urandom_range(0, DW + PW - 1);
    m[a] = 1'b1;
    if (nbits == 2) begin
      b = a;
      while (b == a) b = $urandom_range(0, DW + PW - 1);
      m[b] = 1'b1;
    end
    if (nbits == 0) m = '0;
    df = m[DW-1:0];
    pf = m[DW+PW-1:DW];
  endtask

  function automatic logic [DW-1:0] rdata();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic drain();
    int n;
    in_valid = 1'b0;
    rdy_mode = 0;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      tick();
      n++;
    end
    check_val("drain", 64'(sb.size()), 64'(0));
    tick();
  endtask

  task automatic check_state(input string ph);
    check_val({ph, "_sbit_cnt"}, 64'(sbit_cnt), 64'(sat(exp_s, 65535)));
    check_val({ph, "_dbit_cnt"}, 64'(dbit_cnt), 64'(sat(exp_d, 65535)));
    check_val({ph, "_sbit_cnt4"}, 64'(sbit_cnt4), 64'(sat(exp_s, 15)));
    check_val({ph, "_dbit_cnt4"}, 64'(dbit_cnt4), 64'(sat(exp_d, 15)));
    check_val({ph, "_log_valid"}, 64'(log_valid), 64'(exp_lv));
    check_val({ph, "_log_dbit"}, 64'(log_dbit), 64'(exp_ld));
    check_val({ph, "_log_tag"}, 64'(log_tag), 64'(exp_ltag));
    check_val({ph, "_log_syn"}, 64'(log_syndrome), 64'(exp_lsyn));
  endtask

  task automatic check_reset_state(input string ph);
    check_val({ph, "_out_valid"}, 64'(out_valid), 64'(0));
    check_val({ph, "_out_data"}, 64'(out_data), 64'(0));
    check_val({ph, "_out_tag"}, 64'(out_tag), 64'(0));
    check_val({ph, "_out_syn"}, 64'(out_syndrome), 64'(0));
    check_val({ph, "_out_flags"}, 64'({out_sbit_err, out_dbit_err}), 64'(0));
    check_val({ph, "_cnts"}, 64'({sbit_cnt, dbit_cnt, sbit_cnt4, dbit_cnt4}), 64'(0));
    check_val({ph, "_log"}, 64'({log_valid, log_dbit, log_tag, log_syndrome}), 64'(0));
  endtask

  task automatic clear_model();
    sb.delete();
    exp_s = 0; exp_d = 0;
    exp_lv = 1'b0; exp_ld = 1'b0; exp_ltag = '0; exp_lsyn = '0;
  endtask

  initial begin
    logic [DW-1:0] df, d59;
    logic [PW-1:0] pf;
    int t0, kind;
    n_cmp = 0; n_bad = 0; cyc = 0; rdy_mode = 0; lat_mode = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = '0; in_tag = '0;
    cfg_bypass = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; log_clr = 1'b0;
    cur_exp = '{default: '0};
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    check_val("reset_in_ready", 64'(in_ready), 64'(1));
    tick();
    rst_n = 1'b1;
    tick();

    // clean stream at full rate: latency 2, one word per cycle
    lat_mode = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 1000; i++) send_word(rdata(), TW'(i), '0, '0, 1'b0);
    check_val("throughput", 64'(cyc - t0), 64'(1000));
    lat_mode = 1'b0;
    drain();
    check_state("clean");

    // single errors: data bit 0, data bit 59, parity bit 7
    send_word(rdata(), 8'hA0, DW'(1), '0, 1'b0);
    d59 = '0;
    d59[59] = 1'b1;
    send_word(rdata(), 8'hA1, d59, '0, 1'b0);
    send_word(rdata(), 8'hA2, '0, 8'h80, 1'b0);
    drain();
    check_state("sbit3");
    check_val("sbit3_log_syn_pos", 64'(log_syndrome), 64'(8'h83));

    // double error overwrites the sbit log entry
    df = '0;
    df[3] = 1'b1;
    df[17] = 1'b1;
    send_word(rdata(), 8'hA3, df, '0, 1'b0);
    drain();
    check_state("dbit");

    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
    exp_lv = 1'b0;
    tick();
    check_val("log_clr_alone", 64'(log_valid), 64'(0));

    // log_clr coinciding with the S2 load of a new error
    exp_lv = 1'b0;
    send_word(rdata(), 8'hA4, DW'(1) << 10, '0, 1'b0);
    in_valid = 1'b0;
    log_clr  = 1'b1;
    tick();
    log_clr = 1'b0;
    drain();
    check_state("log_clr_err");

    // random backpressure with mixed error types
    rdy_mode = 1;
    for (int i = 0; i < 500; i++) begin
      kind = $urandom_range(0, 3);
      rand_flip((kind < 2) ? 0 : kind - 1, df, pf);
      send_word(rdata(), TW'(i), df, pf, 1'($urandom_range(0, 9) == 0));
    end
    drain();
    check_state("random");

    // saturation of the narrow counter
    for (int i = 0; i < 20; i++) begin
      rand_flip(1, df, pf);
      send_word(rdata(), TW'(8'hC0 + i), df, pf, 1'b0);
    end
    drain();
    check_state("saturate");
    check_val("sat_cnt4_full", 64'(sbit_cnt4), 64'(15));

    // cnt_clr on the cycle an error loads into S2
    send_word(rdata(), 8'hD0, DW'(1) << 20, '0, 1'b0);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_s = 0;
    exp_d = 0;
    drain();
    check_state("cnt_clr");

    // bypass with a double error: raw data, no flags, no counter/log change
    df = '0;
    df[5] = 1'b1;
    df[40] = 1'b1;
    send_word(rdata(), 8'hB0, df, '0, 1'b1);
    drain();
    check_state("bypass");

    // reset with two words in flight and the output stalled
    rdy_mode = 2;
    tick();
    send_word(rdata(), 8'hE0, '0, '0, 1'b0);
    send_word(rdata(), 8'hE1, DW'(1), '0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    clear_model();
    tick();
    @(negedge clk);
    check_reset_state("midrst");
    check_val("midrst_in_ready", 64'(in_ready), 64'(1));
    tick();
    rst_n = 1'b1;
    rdy_mode = 0;
    tick();
    for (int i = 0; i < 8; i++) send_word(rdata(), TW'(8'hF0 + i), '0, '0, 1'b0);
    drain();
    check_state("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
